// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- fixed-priority interrupt controller with a simple
// request / acknowledge / end-of-service handshake towards the CPU.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high reset
//   irq_in     : N_CH device requests (already synchronous to clk)
//   INT        : interrupt request to the CPU (high while in REQ)
//   INT_ID     : ID of the requesting / in-service channel
//   INT_ACK    : single-cycle CPU acknowledge pulse
//   eret       : single-cycle end-of-service pulse
//   cfg_we     : configuration write strobe
//   cfg_addr   : register select (0 en, 1 pend, 2 ovr, 3 status/gie)
//   cfg_wdata  : configuration write data
//   cfg_rdata  : combinational configuration read data
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int N_CH      = 8,
    parameter int ID_W      = 3,
    parameter int EDGE_MODE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] irq_in,
    output logic            INT,
    output logic [ID_W-1:0] INT_ID,
    input  logic            INT_ACK,
    input  logic            eret,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic [N_CH-1:0]   en_reg;
    logic [N_CH-1:0]   pend_reg, pend_next;
    logic [N_CH-1:0]   ovr_reg, ovr_next;
    logic [N_CH-1:0]   irq_q_reg;
    logic              gie_reg;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   elig;
    logic [ID_W-1:0]   winner;
    logic              any_elig;
    logic              ack_clr;
    logic              cfg_en_wr, cfg_pend_wr, cfg_ovr_wr, cfg_gie_wr;
    logic              unused_wdata;

    assign cfg_en_wr   = cfg_we && (cfg_addr == 2'd0);
    assign cfg_pend_wr = cfg_we && (cfg_addr == 2'd1);
    assign cfg_ovr_wr  = cfg_we && (cfg_addr == 2'd2);
    assign cfg_gie_wr  = cfg_we && (cfg_addr == 2'd3);

    // Only the acknowledge that actually moves REQ -> SERVICE clears pend.
    assign ack_clr = (state_reg == REQ) && INT_ACK;

    // Per-channel capture. Sets always win over same-cycle clears, so an
    // edge that coincides with an acknowledge or a software clear is kept.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic clr_pend;
            assign rise[gi]     = irq_in[gi] & ~irq_q_reg[gi];
            assign clr_pend     = (ack_clr && (id_reg == ID_W'(gi))) ||
                                  (cfg_pend_wr && cfg_wdata[gi]);
            if (EDGE_MODE != 0) begin : g_edge
                assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~clr_pend);
            end else begin : g_level
                assign pend_next[gi] = irq_in[gi];
            end
            assign ovr_next[gi] = (rise[gi] & pend_reg[gi]) |
                                  (ovr_reg[gi] & ~(cfg_ovr_wr & cfg_wdata[gi]));
        end
    endgenerate

    assign elig = gie_reg ? (pend_reg & en_reg) : '0;

    // Lowest eligible index wins: scan downwards so the last hit is lowest.
    always_comb begin
        winner   = '0;
        any_elig = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner   = ID_W'(i);
                any_elig = 1'b1;
            end
        end
    end

    // Next-state logic. The ID is latched only on IDLE -> REQ, so INT_ID is
    // frozen through REQ and SERVICE regardless of en/gie changes.
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (any_elig) begin
                    state_next = REQ;
                    id_next    = winner;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_reg    <= '0;
            pend_reg  <= '0;
            ovr_reg   <= '0;
            irq_q_reg <= '0;
            gie_reg   <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            ovr_reg   <= ovr_next;
            irq_q_reg <= irq_in;
            if (cfg_en_wr) begin
                en_reg <= cfg_wdata[N_CH-1:0];
            end
            if (cfg_gie_wr) begin
                gie_reg <= cfg_wdata[0];
            end
        end
    end

    assign INT    = (state_reg == REQ);
    assign INT_ID = id_reg;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata = 32'(en_reg);
            2'd1: cfg_rdata = 32'(pend_reg);
            2'd2: cfg_rdata = 32'(ovr_reg);
            default: begin
                cfg_rdata[9:8] = state_reg;
                cfg_rdata[7:1] = 7'(id_reg);
                cfg_rdata[0]   = gie_reg;
            end
        endcase
    end

    // Upper write-data bits have no destination for narrow channel counts.
    assign unused_wdata = ^cfg_wdata;

endmodule
